// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Round-robin arbiter that shares NWRITE register-file write ports among
//   NREQ writeback requesters (ALU, MUL, LSU, ...). Each requester uses a
//   valid/ready handshake. A granted write is registered and appears on the
//   regfile write port one cycle after the handshake.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   req_valid[i]          requester i has a write pending
//   req_ready[i]          requester i's write is accepted this cycle (comb)
//   req_rd[i], req_data[i] destination register / write data of requester i
//   flush                 grant nothing this cycle
//   rf_we/rf_waddr/rf_wdata  registered regfile write ports (port 0 first)
//   busy                  at least one rf_we bit set (registered)
//
// Optional feature macro: WBARB_X0_FILTER_EN
//   When defined, a valid request with req_rd==0 is acknowledged at once,
//   takes no write slot, leaves rr_ptr alone and never reaches rf_we.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int NREQ   = 3,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int PW    = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0][AW-1:0]       req_rd,
    input  logic [NREQ-1:0][WIDTH-1:0]    req_data,
    input  logic                          flush,
    output logic [NWRITE-1:0]             rf_we,
    output logic [NWRITE-1:0][AW-1:0]     rf_waddr,
    output logic [NWRITE-1:0][WIDTH-1:0]  rf_wdata,
    output logic                          busy
);

    // Registered state
    logic [PW-1:0]                 rr_ptr_q,   rr_ptr_d;
    logic [NWRITE-1:0]             rf_we_q,    rf_we_d;
    logic [NWRITE-1:0][AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [NWRITE-1:0][WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic                          busy_q,     busy_d;

    // Grant selection results
    logic [NREQ-1:0]               grant;
    logic [NREQ-1:0]               x0_ack;
    logic [NWRITE-1:0]             port_vld;
    logic [NWRITE-1:0][PW-1:0]     port_sel;
    logic [PW-1:0]                 last_grant;

    // Scan requesters from rr_ptr with wrap-around; the first NWRITE valid
    // ones fill ports 0..NWRITE-1 in scan order. Only req_valid, rr_ptr and
    // flush (plus req_rd when the x0 filter is on) feed this, so req_ready
    // never loops back through the requesters.
    always_comb begin
        int  idx;
        int  nslot;
        logic is_x0;
        grant      = '0;
        x0_ack     = '0;
        port_vld   = '0;
        port_sel   = '0;
        last_grant = rr_ptr_q;
        nslot      = 0;
        idx        = 0;
        is_x0      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
`ifdef WBARB_X0_FILTER_EN
            is_x0 = (req_rd[idx] == '0);
`else
            is_x0 = 1'b0;
`endif
            if (!flush && req_valid[idx]) begin
                if (is_x0) begin
                    x0_ack[idx] = 1'b1;
                end else if (nslot < NWRITE) begin
                    grant[idx]      = 1'b1;
                    port_vld[nslot] = 1'b1;
                    port_sel[nslot] = PW'(idx);
                    last_grant      = PW'(idx);
                    nslot           = nslot + 1;
                end
            end
        end
    end

    assign req_ready = grant | x0_ack;

    // Pointer moves just past the last granted requester; held otherwise.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            if (last_grant == PW'(NREQ - 1)) rr_ptr_d = '0;
            else                             rr_ptr_d = last_grant + 1'b1;
        end
    end

    // Output port next state; address/data hold when the port is idle.
    always_comb begin
        for (int k = 0; k < NWRITE; k++) begin
            rf_we_d[k]    = port_vld[k];
            rf_waddr_d[k] = port_vld[k] ? req_rd[port_sel[k]]   : rf_waddr_q[k];
            rf_wdata_d[k] = port_vld[k] ? req_data[port_sel[k]] : rf_wdata_q[k];
        end
        busy_d = |rf_we_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule
